vending_machine_param: RTL

Parametrised multi-product vending controller that supersedes the fixed two-coin, single-price machine. It accumulates coin credit, vends any of NUM_PROD products against a runtime price table, and returns change one coin at a time over a valid/ready handshake. It sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

---
 rtl/vending_machine_param.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/vending_machine_param.sv
// Multi-product vending controller: coin credit, price-table vend and change returned one coin per valid/ready handshake.
// All outputs registered (1-cycle latency); chg_valid/chg_coin hold until chg_ready; `VEND_TIMEOUT_EN adds an inactivity refund.
module vending_machine_param #(
  parameter int NUM_PROD    = 4,
  parameter int PRICE_W     = 8,
  parameter int CREDIT_W    = 8,
  parameter int TIMEOUT_CYC = 1024,
  localparam int IDX_W      = $clog2(NUM_PROD)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_coin_valid,
  input  logic [1:0]                  i_coin_val,
  input  logic                        i_sel_valid,
  input  logic [IDX_W-1:0]            i_sel_idx,
  input  logic                        i_cancel,
  input  logic [NUM_PROD*PRICE_W-1:0] i_prices,
  input  logic                        i_chg_ready,
  output logic [CREDIT_W-1:0]         o_credit,
  output logic                        o_coin_reject,
  output logic                        o_vend,
  output logic [IDX_W-1:0]            o_vend_idx,
  output logic                        o_short_pulse,
  output logic                        o_chg_valid,
  output logic [1:0]                  o_chg_coin,
  output logic                        o_busy
);

  localparam int MAX_W = (CREDIT_W > PRICE_W) ? CREDIT_W : PRICE_W;
  localparam int CMP_W = ((MAX_W > 5) ? MAX_W : 5) + 1;
  localparam logic [CMP_W-1:0] CREDIT_MAX = CMP_W'((2 ** CREDIT_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic                r_coin_reject, w_reject_nxt;
  logic                r_vend;
  logic [IDX_W-1:0]    r_vend_idx, w_vend_idx_nxt;
  logic                r_short, w_short_nxt;
  logic                r_chg_valid;
  logic [1:0]          r_chg_coin, w_chg_coin_nxt;
  logic                r_busy;

  logic [CMP_W-1:0]    w_coin_amt, w_credit_ext, w_price_ext, w_sum, w_chg_amt, w_rem;
  logic [PRICE_W-1:0]  w_price;
  logic                w_coin_live, w_coin_fits, w_sel_ok, w_afford, w_coin_acc, w_tmo_fire;

  always_comb begin
    case (i_coin_val)
      2'b01:   w_coin_amt = CMP_W'(5);
      2'b10:   w_coin_amt = CMP_W'(10);
      2'b11:   w_coin_amt = CMP_W'(20);
      default: w_coin_amt = '0;
    endcase
  end

  assign w_coin_live  = i_coin_valid && (i_coin_val != 2'b00);
  assign w_credit_ext = CMP_W'(r_credit);
  assign w_sum        = w_credit_ext + w_coin_amt;
  assign w_coin_fits  = (w_sum <= CREDIT_MAX);
  assign w_price      = i_prices[int'(i_sel_idx)*PRICE_W +: PRICE_W];
  assign w_price_ext  = CMP_W'(w_price);

  // Index codes past NUM_PROD (non power-of-two tables) select nothing.
  if ((2 ** IDX_W) == NUM_PROD) begin : g_sel_full
    assign w_sel_ok = 1'b1;
  end else begin : g_sel_part
    assign w_sel_ok = (int'(i_sel_idx) < NUM_PROD);
  end

  assign w_afford  = w_sel_ok && (w_credit_ext >= w_price_ext);
  assign w_chg_amt = (r_chg_coin == 2'b10) ? CMP_W'(10) : CMP_W'(5);
  assign w_rem     = w_credit_ext - w_chg_amt;

`ifdef VEND_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] r_tmo;

  assign w_tmo_fire = (r_state == S_CREDIT) && (r_tmo == TMO_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo <= '0;
    end else if ((w_state_nxt != S_CREDIT) || w_coin_acc || i_sel_valid) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + 1'b1;
    end
  end
`else
  assign w_tmo_fire = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_credit_nxt   = r_credit;
    w_reject_nxt   = 1'b0;
    w_vend_idx_nxt = r_vend_idx;
    w_short_nxt    = 1'b0;
    w_coin_acc     = 1'b0;
    case (r_state)
      S_IDLE, S_CREDIT: begin
        if ((r_state == S_CREDIT) && (i_cancel || w_tmo_fire)) begin
          w_state_nxt  = S_CHANGE;
          w_reject_nxt = w_coin_live;
        end else if ((r_state == S_CREDIT) && i_sel_valid && w_afford) begin
          w_state_nxt    = S_VEND;
          w_credit_nxt   = CREDIT_W'(w_credit_ext - w_price_ext);
          w_vend_idx_nxt = i_sel_idx;
          w_reject_nxt   = w_coin_live;
        end else begin
          // A short select is not an accepted select, so a coin in that cycle still counts.
          w_short_nxt = (r_state == S_CREDIT) && i_sel_valid;
          if (w_coin_live) begin
            if (w_coin_fits) begin
              w_credit_nxt = CREDIT_W'(w_sum);
              w_state_nxt  = S_CREDIT;
              w_coin_acc   = 1'b1;
            end else begin
              w_reject_nxt = 1'b1;
            end
          end
        end
      end
      S_VEND: begin
        w_reject_nxt = w_coin_live;
        // Leftover below the smallest change coin cannot be returned.
        if (w_credit_ext >= CMP_W'(5)) begin
          w_state_nxt = S_CHANGE;
        end else begin
          w_credit_nxt = '0;
          w_state_nxt  = S_IDLE;
        end
      end
      S_CHANGE: begin
        w_reject_nxt = w_coin_live;
        if (r_chg_valid && i_chg_ready) begin
          if (w_rem < CMP_W'(5)) begin
            w_credit_nxt = '0;
            w_state_nxt  = S_IDLE;
          end else begin
            w_credit_nxt = CREDIT_W'(w_rem);
          end
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_credit_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_chg_coin_nxt = 2'b00;
    if (w_state_nxt == S_CHANGE) begin
      w_chg_coin_nxt = (CMP_W'(w_credit_nxt) >= CMP_W'(10)) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_credit      <= '0;
      r_coin_reject <= 1'b0;
      r_vend        <= 1'b0;
      r_vend_idx    <= '0;
      r_short       <= 1'b0;
      r_chg_valid   <= 1'b0;
      r_chg_coin    <= 2'b00;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_credit      <= w_credit_nxt;
      r_coin_reject <= w_reject_nxt;
      r_vend        <= (w_state_nxt == S_VEND);
      r_vend_idx    <= w_vend_idx_nxt;
      r_short       <= w_short_nxt;
      r_chg_valid   <= (w_state_nxt == S_CHANGE);
      r_chg_coin    <= w_chg_coin_nxt;
      r_busy        <= (w_state_nxt == S_VEND) || (w_state_nxt == S_CHANGE);
    end
  end

  assign o_credit      = r_credit;
  assign o_coin_reject = r_coin_reject;
  assign o_vend        = r_vend;
  assign o_vend_idx    = r_vend_idx;
  assign o_short_pulse = r_short;
  assign o_chg_valid   = r_chg_valid;
  assign o_chg_coin    = r_chg_coin;
  assign o_busy        = r_busy;

endmodule
